// File: rtl/fns_serial_decoder.sv
// Serial Fibonacci-numeral-system decoder for the CAC TSV link: one TSV per clock,
// skipping disabled TSVs, with forbidden-transition checking against the previous word.
module fns_serial_decoder #(
  parameter int NTSV = 5,
  parameter int BLEN = 7
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NTSV-1:0] tsv,
  input  logic [NTSV-1:0] en_flag,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [BLEN-1:0] dataout,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            ftf_err
);

  localparam int IW = (NTSV > 1) ? $clog2(NTSV) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]      state_r;
  logic [BLEN-1:0] acc_r;
  logic [BLEN-1:0] fa_r;
  logic [BLEN-1:0] fb_r;
  logic [IW-1:0]   idx_r;
  logic [NTSV-1:0] prev_code_r;
  logic [NTSV-1:0] code_r;
  logic [NTSV-1:0] en_r;
  logic            ftf_pend_r;
  logic            in_ready_r;
  logic            out_valid_r;
  logic [BLEN-1:0] dataout_r;
  logic            ftf_err_r;

  logic            ftf_s;
  logic            cur_en_s;
  logic            cur_bit_s;
  logic            last_s;
  logic [BLEN-1:0] acc_nxt_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign dataout   = dataout_r;
  assign ftf_err   = ftf_err_r;

  // Opposite-direction transitions on two adjacent enabled wires are forbidden.
  always_comb begin
    ftf_s = 1'b0;
    for (int i = 0; i < NTSV - 1; i++) begin
      ftf_s = ftf_s | (en_flag[i] & en_flag[i+1] &
                       ((~prev_code_r[i] & tsv[i] & prev_code_r[i+1] & ~tsv[i+1]) |
                        (prev_code_r[i] & ~tsv[i] & ~prev_code_r[i+1] & tsv[i+1])));
    end
  end

  // Current TSV contribution; disabled TSVs add nothing and consume no weight.
  always_comb begin
    cur_en_s  = en_r[idx_r];
    cur_bit_s = code_r[idx_r];
    last_s    = (idx_r == IW'(NTSV - 1));
    if (cur_en_s && cur_bit_s) begin
      acc_nxt_s = acc_r + fa_r;
    end else begin
      acc_nxt_s = acc_r;
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      acc_r       <= {BLEN{1'b0}};
      fa_r        <= {BLEN{1'b0}};
      fb_r        <= {BLEN{1'b0}};
      idx_r       <= {IW{1'b0}};
      prev_code_r <= {NTSV{1'b0}};
      code_r      <= {NTSV{1'b0}};
      en_r        <= {NTSV{1'b0}};
      ftf_pend_r  <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      dataout_r   <= {BLEN{1'b0}};
      ftf_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_ready_r && in_valid) begin
            code_r      <= tsv;
            en_r        <= en_flag;
            prev_code_r <= tsv;
            ftf_pend_r  <= ftf_s;
            acc_r       <= {BLEN{1'b0}};
            fa_r        <= BLEN'(1);
            fb_r        <= BLEN'(1);
            idx_r       <= {IW{1'b0}};
            in_ready_r  <= 1'b0;
            state_r     <= ST_DECODE;
          end else begin
            in_ready_r  <= 1'b1;
          end
        end
        ST_DECODE: begin
          acc_r <= acc_nxt_s;
          idx_r <= idx_r + IW'(1);
          if (cur_en_s) begin
            fa_r <= fb_r;
            fb_r <= fa_r + fb_r;
          end
          if (last_s) begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
            dataout_r   <= acc_nxt_s;
            ftf_err_r   <= ftf_pend_r;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fns_serial_decoder.sv
// Randomized self-checking bench for fns_serial_decoder against a Fibonacci-weight reference model.
module tb_fns_serial_decoder;

  localparam int NTSV = 5;
  localparam int BLEN = 7;

  logic            clock;
  logic            reset;
  logic [NTSV-1:0] tsv;
  logic [NTSV-1:0] en_flag;
  logic            in_valid;
  logic            in_ready;
  logic [BLEN-1:0] dataout;
  logic            out_valid;
  logic            out_ready;
  logic            ftf_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [NTSV-1:0] prev_model = '0;
  logic [BLEN-1:0] got_d;
  logic            got_f;

  fns_serial_decoder #(.NTSV(NTSV), .BLEN(BLEN)) dut (
    .clock(clock), .reset(reset), .tsv(tsv), .en_flag(en_flag),
    .in_valid(in_valid), .in_ready(in_ready), .dataout(dataout),
    .out_valid(out_valid), .out_ready(out_ready), .ftf_err(ftf_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // k-th enabled TSV carries the k-th Fibonacci number 1,1,2,3,5...
  function automatic logic [BLEN-1:0] ref_decode(input logic [NTSV-1:0] c, input logic [NTSV-1:0] e);
    int fib[NTSV];
    int k;
    int sum;
    fib[0] = 1;
    if (NTSV > 1) fib[1] = 1;
    for (int i = 2; i < NTSV; i++) fib[i] = fib[i-1] + fib[i-2];
    k = 0;
    sum = 0;
    for (int i = 0; i < NTSV; i++) begin
      if (e[i]) begin
        if (c[i]) sum += fib[k];
        k++;
      end
    end
    return BLEN'(sum % (1 << BLEN));
  endfunction

  // Forbidden: adjacent enabled wires move in opposite directions (product of deltas is -1).
  function automatic logic ref_ftf(input logic [NTSV-1:0] p, input logic [NTSV-1:0] c, input logic [NTSV-1:0] e);
    int d0;
    int d1;
    logic v;
    v = 1'b0;
    for (int i = 0; i < NTSV - 1; i++) begin
      d0 = int'(c[i]) - int'(p[i]);
      d1 = int'(c[i+1]) - int'(p[i+1]);
      if (e[i] && e[i+1] && (d0 * d1 == -1)) v = 1'b1;
    end
    return v;
  endfunction

  // Sends one word starting at a negedge, checks latency/result/backpressure, ends at a negedge.
  task automatic send_word(input logic [NTSV-1:0] c, input logic [NTSV-1:0] e, input int bp,
                           input bit scramble, output logic [BLEN-1:0] od, output logic of);
    logic [BLEN-1:0] exp_d;
    logic            exp_f;
    int cnt;
    int w;
    exp_d = ref_decode(c, e);
    exp_f = ref_ftf(prev_model, c, e);
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clock);
      w++;
    end
    check_eq("in_ready_idle", in_ready, 1);
    tsv = c; en_flag = e; in_valid = 1'b1;
    @(posedge clock);
    prev_model = c;
    cnt = 1;
    while (cnt < 20) begin
      @(negedge clock);
      if (out_valid) break;
      check_eq("in_ready_busy", in_ready, 0);
      in_valid = scramble ? 1'($urandom_range(0, 1)) : 1'b0;
      if (scramble) begin
        tsv = NTSV'($urandom);
        en_flag = NTSV'($urandom);
      end
      @(posedge clock);
      cnt++;
    end
    check_eq("latency", cnt, NTSV + 1);
    check_eq("dataout", dataout, exp_d);
    check_eq("ftf_err", ftf_err, exp_f);
    od = dataout;
    of = ftf_err;
    for (int j = 0; j < bp; j++) begin
      in_valid = 1'($urandom_range(0, 1));
      tsv = NTSV'($urandom);
      @(posedge clock);
      @(negedge clock);
      check_eq("bp_out_valid", out_valid, 1);
      check_eq("bp_dataout", dataout, exp_d);
      check_eq("bp_ftf_err", ftf_err, exp_f);
      check_eq("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    check_eq("hs_out_valid", out_valid, 0);
    check_eq("hs_in_ready", in_ready, 1);
  endtask

  initial begin
    reset = 1'b1; tsv = '0; en_flag = '0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_dataout", dataout, 0);
    check_eq("rst_ftf_err", ftf_err, 0);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check_eq("rel_in_ready", in_ready, 1);

    send_word(5'b10101, 5'b11111, 0, 1'b0, got_d, got_f);
    check_eq("healthy_val", got_d, 8);
    send_word(5'b11011, 5'b11011, 0, 1'b0, got_d, got_f);
    check_eq("faulty_val", got_d, 7);
    send_word(5'b00100, 5'b11011, 0, 1'b0, got_d, got_f);
    check_eq("faulty_zero", got_d, 0);

    send_word(5'b00010, 5'b11111, 0, 1'b0, got_d, got_f);
    send_word(5'b00001, 5'b11111, 0, 1'b0, got_d, got_f);
    check_eq("ftf_hit", got_f, 1);
    send_word(5'b00010, 5'b11111, 0, 1'b0, got_d, got_f);
    send_word(5'b00001, 5'b11100, 3, 1'b1, got_d, got_f);
    check_eq("ftf_masked", got_f, 0);

    send_word(5'b11111, 5'b11111, 2, 1'b1, got_d, got_f);
    check_eq("snapshot_val", got_d, 12);
    send_word(5'b10110, 5'b00000, 1, 1'b0, got_d, got_f);
    check_eq("all_off_val", got_d, 0);
    check_eq("all_off_ftf", got_f, 0);

    // Reset while idx=2 in DECODE discards the word and clears prev_code.
    tsv = 5'b11101; en_flag = 5'b11111; in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_in_ready", in_ready, 0);
    check_eq("mid_rst_dataout", dataout, 0);
    @(negedge clock);
    reset = 1'b0;
    prev_model = '0;
    @(posedge clock);
    @(negedge clock);
    check_eq("mid_rel_in_ready", in_ready, 1);
    check_eq("mid_rel_out_valid", out_valid, 0);
    send_word(5'b00010, 5'b11111, 0, 1'b0, got_d, got_f);
    check_eq("post_rst_ftf", got_f, 0);

    for (int n = 0; n < 40; n++) begin
      send_word(NTSV'($urandom), NTSV'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                got_d, got_f);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fns_serial_decoder.md
Name: fns_serial_decoder

Overview:
- Receiver-side Fibonacci-numeral-system (FNS) decoder for the fault-tolerant CAC TSV link.
- Accepts one TSV codeword per handshake and decodes it serially, one TSV per clock, skipping TSVs that the enable flags mark as disabled (faulty).
- Checks each new codeword against the previous one for forbidden adjacent transitions, and flags any violation alongside the decoded data.
- Sits between the TSV bundle and the receiver datapath; it is the multi-cycle, area-light alternative to the combinational decoder.

Parameters:
NTSV, 5, number of physical TSVs in the bundle (x+y).
BLEN, 7, decoded data width; the accumulator wraps modulo 2^BLEN.

Ports:
clock  input  1  rising-edge clock.
reset  input  1  asynchronous active-high reset.
tsv  input  NTSV  received codeword; tsv[0] is the first TSV and the LSB weight position.
en_flag  input  NTSV  per-TSV enable; 1 = healthy/used, 0 = faulty/skipped.
in_valid  input  1  tsv/en_flag valid.
in_ready  output  1  decoder idle and able to accept.
dataout  output  BLEN  decoded value.
out_valid  output  1  dataout/ftf_err valid.
out_ready  input  1  downstream accepts dataout.
ftf_err  output  1  forbidden-transition violation detected for this codeword.

Behaviour:
- Reset values: in_ready=0 while reset is asserted, then 1 in the first cycle after release. out_valid=0, dataout=0, ftf_err=0. The state machine is in IDLE and all internal registers (acc, fa, fb, idx, prev_code, code_r, en_r) are 0.
- State IDLE: in_ready=1. On a clock edge with in_valid=1, latch code_r<=tsv and en_r<=en_flag. Set acc<=0, fa<=1, fb<=1, idx<=0, then go to DECODE.
- FTF check at acceptance: for each i in 0..NTSV-2 where en_flag[i] and en_flag[i+1] are both 1, a violation exists if (prev_code[i],tsv[i],prev_code[i+1],tsv[i+1]) is 0→1 on wire i with 1→0 on wire i+1, or 1→0 on wire i with 0→1 on wire i+1. The OR of all violations is registered into ftf_pend. prev_code<=tsv on every acceptance.
- State DECODE: one edge per TSV, for idx=0..NTSV-1.
  - If en_r[idx]=1: when code_r[idx]=1, acc<=acc+fa (BLEN-bit wrap). Then (fa,fb)<=(fb,fa+fb), giving weights 1,1,2,3,5,8...
  - If en_r[idx]=0: acc, fa and fb are unchanged, so a disabled TSV consumes no weight.
  - After the edge with idx=NTSV-1, go to DONE.
- DECODE takes exactly NTSV cycles. out_valid rises NTSV+1 edges after the acceptance edge (edges counted from and including the acceptance edge).
- State DONE: out_valid=1, dataout=acc, ftf_err=ftf_pend. These are held stable until an edge with out_ready=1. On that edge, out_valid<=0 and the state returns to IDLE; in_ready is 1 in the following cycle. There is no bypass: a back-to-back throughput of one word per NTSV+2 cycles is required.
- in_ready=0 in DECODE and DONE. in_valid in those states is ignored and causes no capture.
- Changes on en_flag or tsv after acceptance have no effect on the word in flight, because decode uses the en_r/code_r snapshots.
- All en_flag bits 0: decode still takes NTSV cycles and dataout=0. ftf_err=0, since no pair is enabled.
- Reset asserted mid-DECODE or in DONE: immediately return to IDLE. Outputs return to reset values, the word is discarded, and prev_code is cleared to 0.
- dataout and ftf_err are driven from registers and are don't-care-but-stable (held at their last value) while out_valid=0.

Test Plan:
- Healthy link: en_flag=11111, tsv=10101 accepted → out_valid asserted NTSV+1=6 edges later with dataout=8 (1+2+5), ftf_err=0.
- One faulty TSV: en_flag=11011, tsv=11011 → weights 1,1,-,2,3 → dataout=7. Repeat with tsv=00100 → dataout=0.
- FTF violation: accept tsv=00010 then tsv=00001, en_flag=11111 → second word ftf_err=1. Repeat with en_flag=11100 → ftf_err=0, because the violating pair is disabled.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid → dataout, out_valid and ftf_err stay stable, in_ready=0, no capture. Then out_ready=1 → IDLE, in_ready=1 next cycle.
- Snapshot integrity: after accepting tsv=11111 with en_flag=11111, drive en_flag=00000 during DECODE → dataout=12.
- Reset mid-DECODE at idx=2 → out_valid=0, in_ready=1 after release. Next word tsv=00010 gives ftf_err=0, because prev_code was cleared.
